// File: rtl/addsub_arbiter.sv
// Two-requester front end for a shared 16-bit saturating add/sub unit.
// One operation is in flight at a time; the result is held until the consumer takes it.
module addsub_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_sub,
  output logic        alu_padd,
  output logic        alu_red,
  input  logic [15:0] alu_s,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  input  logic        rsp_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PADD = 2'b10;
  localparam logic [1:0] OP_RED  = 2'b11;

  state_t      state;
  state_t      state_next;
  logic [1:0]  cap_op;
  logic [15:0] cap_a;
  logic [15:0] cap_b;
  logic        cap_id;
  logic        last_grant;
  logic        accept_ok;
  logic        grant;
  logic        handshake;

  // A new operation may enter only when nothing is executing and no response is stuck in HOLD.
  always_comb begin
    accept_ok = (state == IDLE) || ((state == HOLD) && rsp_ready);
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    req0_ready = !rst && accept_ok && req0_valid && !grant;
    req1_ready = !rst && accept_ok && req1_valid && grant;
    handshake  = req0_ready || req1_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (handshake) state_next = EXEC;
      end
      EXEC: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (handshake) begin
          state_next = EXEC;
        end else if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the winning request, then latch the unit's result one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_op     <= 2'b00;
      cap_a      <= 16'h0000;
      cap_b      <= 16'h0000;
      cap_id     <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= 16'h0000;
      rsp_id     <= 1'b0;
    end else begin
      if (handshake) begin
        cap_op     <= grant ? req1_op : req0_op;
        cap_a      <= grant ? req1_a  : req0_a;
        cap_b      <= grant ? req1_b  : req0_b;
        cap_id     <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_data  <= alu_s;
        rsp_id    <= cap_id;
      end else if ((state == HOLD) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    alu_a    = cap_a;
    alu_b    = cap_b;
    alu_sub  = (cap_op == OP_SUB);
    alu_padd = (cap_op == OP_PADD);
    alu_red  = (cap_op == OP_RED);
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Port clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Ports req0_valid/req1_valid  input  1  requester N presents an operation.
REQ-005 Ports req0_ready/req1_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 Ports req0_op/req1_op  input  2  opcode: 00 ADD, 01 SUB, 10 PADDSB, 11 RED.
REQ-007 Ports req0_a, req0_b, req1_a, req1_b  input  16  operands.
REQ-008 Ports alu_a, alu_b  output  16  operands to the shared 16-bit saturating add/sub unit.
REQ-009 Ports alu_sub, alu_padd, alu_red  output  1  mode controls to the shared unit; at most one SHALL be high at a time.
REQ-010 Port alu_s  input  16  combinational result from the shared unit.
REQ-011 Port rsp_valid  output  1  response held for the consumer.
REQ-012 Port rsp_id  output  1  requester index that owns the response.
REQ-013 Port rsp_data  output  16  captured result.
REQ-014 Port rsp_ready  input  1  consumer takes the response.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC and HOLD.
REQ-016 Operation acceptance:
- Accept is allowed in IDLE, or in HOLD in the same cycle that rsp_ready=1.
- reqN_ready SHALL be high only when accept is allowed and requester N is granted.
- A handshake is reqN_valid & reqN_ready.
REQ-017 Arbitration:
- Single valid requester: it is granted.
- Both valid: grant the requester that is not last_grant.
- last_grant SHALL update on every handshake.
REQ-018 On a handshake, op, a, b and id SHALL be captured into internal registers, and the FSM SHALL move to EXEC.
REQ-019 alu_a, alu_b and the mode controls SHALL always be driven from the captured registers, never directly from the request inputs. Decode:
- ADD: all controls low.
- SUB: alu_sub=1.
- PADDSB: alu_padd=1.
- RED: alu_red=1.
REQ-020 In EXEC (exactly one cycle), the block SHALL latch alu_s into rsp_data and the captured id into rsp_id, set rsp_valid, and go to HOLD.
REQ-021 Latency: handshake in cycle T -> rsp_valid high from cycle T+2.
REQ-022 HOLD behaviour:
- rsp_valid, rsp_data and rsp_id SHALL be held stable while rsp_ready=0.
- On rsp_ready=1 with no new handshake: clear rsp_valid and go to IDLE.
- On rsp_ready=1 with a handshake in the same cycle: go directly to EXEC.
REQ-023 No handshake SHALL occur in EXEC, or in HOLD while rsp_ready=0.
REQ-024 The arbiter SHALL NOT modify results; saturation and lane behaviour belong to the shared unit.
REQ-025 Requester inputs changing while not granted SHALL have no effect on state.
REQ-026 rsp_ready asserted while rsp_valid=0 SHALL be ignored.

Reset
REQ-027 While rst=1, the block SHALL hold: state=IDLE, rsp_valid=0, rsp_data=0x0000, rsp_id=0, last_grant=1, and all captured operand/op registers=0.
REQ-028 As a consequence of REQ-027, alu_a=alu_b=0x0000 and all alu controls are 0 during reset.
REQ-029 req0_ready and req1_ready SHALL be forced to 0 while rst=1.
REQ-030 rst asserted in EXEC or HOLD SHALL discard the in-flight operation; no response for it SHALL ever appear.
REQ-031 After rst deasserts, the first tie SHALL be granted to requester 0.

Verification
REQ-032 The bench, using the real shared add/sub unit, SHALL cover these scenarios:
- req0 only, ADD 0x0003+0x0004, rsp_ready=1 -> req0_ready=1 at T; rsp_valid=1, rsp_data=0x0007, rsp_id=0 at T+2.
- Both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id follows the same order.
- Saturation: req1 ADD 0x7FFF+0x0001 -> rsp_data=0x7FFF; SUB 0x8000-0x0001 -> rsp_data=0x8000; alu_sub=1 only for the SUB.
- rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_data/rsp_id stable; both readys stay 0; on rsp_ready=1, rsp_valid drops next cycle.
- In HOLD, rsp_ready=1 with req1_valid=1 -> req1_ready=1 in that same cycle; next response valid 2 cycles later.
- rst pulsed during EXEC of a SUB -> rsp_valid=0 immediately; no response for that SUB; next tie granted to requester 0.
